data_mem_bridge: RTL and testbench
==================================

Name: data_mem_bridge

Overview:
- Sits directly downstream of the Memory stage. It turns the stage's access request (mode, address, write enable, extend flag, store data) into one transaction on the SRAM-like data bus.
- It returns aligned and extended load data on MemoryRead.
- It holds the pipeline with Stall until the transaction completes.
- It detects misaligned addresses and reports them to exception logic instead of issuing a bus access.

Parameters:
- ADDR_W, 32, width of Addr and DataAddr.
- DATA_W, 32, width of data buses; fixed at 32, other values unsupported.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemReadEn  in  1  Memory stage requests a load
- MemWriteEn  in  1  Memory stage requests a store
- Mode  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- MemoryExtend  in  1  loads only: 1 sign-extend, 0 zero-extend
- Addr  in  32  byte address
- MemoryWrite  in  32  store data, right-aligned
- Flush  in  1  squash the instruction currently in Memory
- MemoryRead  out  32  aligned, extended load result
- Stall  out  1  freeze all stages up to and including Memory
- AddrErrLoad  out  1  misaligned load (AdEL)
- AddrErrStore  out  1  misaligned store (AdES)
- DataReq  out  1  bus request
- DataWr  out  1  1 store, 0 load
- DataSize  out  2  0 byte, 1 half, 2 word
- DataAddr  out  32  bus address, unaligned byte address passed through
- DataWData  out  32  lane-replicated store data
- DataAddrOk  in  1  slave accepted the address
- DataDataOk  in  1  slave returned data or write ack
- DataRData  in  32  raw read word

Behaviour:
- Access = (MemReadEn | MemWriteEn) & ~Flush & ~Misaligned.
- Misaligned = (Mode==01 & Addr[0]) | (Mode>=10 & Addr[1:0]!=0).
- AddrErrLoad = MemReadEn & Misaligned & ~Flush. AddrErrStore = MemWriteEn & Misaligned & ~Flush.
- Both error outputs are combinational, asserted only in IDLE. No bus activity follows an error.
- MemReadEn and MemWriteEn both high: treat as store.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - Access=1: latch Addr, Mode, MemoryExtend, write flag and replicated data into request registers; assert Stall; go to ADDR.
  - Otherwise Stall=0; stay in IDLE.
- ADDR:
  - DataReq=1; bus outputs come only from request registers. Stall=1.
  - DataAddrOk & DataDataOk in the same cycle: capture, go to DONE.
  - DataAddrOk only: go to DATA.
  - Neither: hold all bus outputs stable.
- DATA:
  - DataReq=0, Stall=1.
  - On DataDataOk: capture DataRData (loads) and go to DONE.
- DONE:
  - Stall=0; MemoryRead valid; pipeline advances at this edge.
  - Next state is IDLE unconditionally, so the same instruction never issues twice.
- Minimum latency with a zero-wait slave: 3 cycles (IDLE, ADDR, DONE); Stall is high for 2 of them.
- Store data replication:
  - byte: {4{MemoryWrite[7:0]}}
  - half: {2{MemoryWrite[15:0]}}
  - word: pass through
- Load extraction:
  - Shift captured word right by 8*Addr[1:0].
  - Take the low 8 or 16 bits (or all 32 for word).
  - Sign- or zero-extend per the latched extend flag.
- MemoryRead is registered and holds its value until the next load completes. Stores leave it unchanged.
- Flush in IDLE: no transaction. Flush in ADDR/DATA is ignored: a bus transaction is never abandoned, and Stall stays high until DONE.
- Reset: state IDLE; DataReq=0, DataWr=0, DataSize=0, DataAddr=0, DataWData=0, MemoryRead=0, Stall=0, error outputs 0.
- Reset in any state returns to IDLE next edge. The slave must be reset by the same signal.

Test Plan:
- Zero-wait slave; load word Addr=0x80000010; DataRData=0xDEADBEEF, AddrOk and DataOk same cycle:
  - Stall high 2 cycles.
  - DataSize=2.
  - MemoryRead=0xDEADBEEF in DONE.
- Signed byte load at Addr=0x103, DataRData=0x80112233 -> MemoryRead=0xFFFFFF80. Unsigned byte load at the same address -> 0x00000080.
- Store half at Addr=0x202, MemoryWrite=0x1234ABCD -> DataWData=0xABCDABCD, DataSize=1, DataWr=1, DataAddr=0x202.
- Load word at Addr=0x6 -> AddrErrLoad=1, Stall=0, DataReq stays 0. Store half at 0x5 -> AddrErrStore=1.
- Slave delays AddrOk 2 cycles, then DataOk 3 cycles:
  - DataReq and bus outputs stable for 3 cycles.
  - Stall high for 7 cycles total.
  - Exactly one request issued.
- Flush asserted during DATA: transaction completes, Stall holds until DONE. Then reset during ADDR: next cycle IDLE, DataReq=0, Stall=0.

Source files
------------

// File: rtl/data_mem_bridge.sv
// Bridge between the Memory stage and an SRAM-like data bus: one bus transaction per
// load/store, load alignment/extension, pipeline stall and misaligned-address detection.
module data_mem_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadEn,
  input  logic              MemWriteEn,
  input  logic [1:0]        Mode,
  input  logic              MemoryExtend,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] MemoryWrite,
  input  logic              Flush,
  output logic [DATA_W-1:0] MemoryRead,
  output logic              Stall,
  output logic              AddrErrLoad,
  output logic              AddrErrStore,
  output logic              DataReq,
  output logic              DataWr,
  output logic [1:0]        DataSize,
  output logic [ADDR_W-1:0] DataAddr,
  output logic [DATA_W-1:0] DataWData,
  input  logic              DataAddrOk,
  input  logic              DataDataOk,
  input  logic [DATA_W-1:0] DataRData
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t              state;
  logic                req_ext;
  logic [DATA_W-1:0]   mem_read;
  logic                misaligned;
  logic                access;

  function automatic logic [1:0] size_of(input logic [1:0] mode);
    case (mode)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] mode, input logic [31:0] wdata);
    case (mode)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic ext);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return {{24{ext & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{ext & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign misaligned = ((Mode == 2'b01) && Addr[0]) || (Mode[1] && (Addr[1:0] != 2'b00));
  assign access     = (MemReadEn | MemWriteEn) & ~Flush & ~misaligned;

  // Stall covers the issuing IDLE cycle too, so the pipeline freezes before the bus phase.
  assign Stall        = ((state == IDLE) & access) | (state == ADDR) | (state == DATA);
  assign AddrErrLoad  = (state == IDLE) & MemReadEn & misaligned & ~Flush;
  assign AddrErrStore = (state == IDLE) & MemWriteEn & misaligned & ~Flush;
  assign MemoryRead   = mem_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      DataReq   <= 1'b0;
      DataWr    <= 1'b0;
      DataSize  <= 2'd0;
      DataAddr  <= '0;
      DataWData <= '0;
      req_ext   <= 1'b0;
      mem_read  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            DataAddr  <= Addr;
            DataSize  <= size_of(Mode);
            DataWr    <= MemWriteEn;
            DataWData <= replicate_store(Mode, MemoryWrite);
            req_ext   <= MemoryExtend;
            DataReq   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // Bus outputs hold until the slave takes the address; Flush cannot abort it.
          if (DataAddrOk) begin
            DataReq <= 1'b0;
            if (DataDataOk) begin
              if (!DataWr)
                mem_read <= extract_load(DataRData, DataAddr[1:0], DataSize, req_ext);
              state <= DONE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (DataDataOk) begin
            if (!DataWr)
              mem_read <= extract_load(DataRData, DataAddr[1:0], DataSize, req_ext);
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: directed accesses against a configurable-latency
// slave; bus and completion expectations are queued and checked by a monitor.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadEn, MemWriteEn, MemoryExtend, Flush;
  logic [1:0]  Mode;
  logic [31:0] Addr, MemoryWrite;
  logic [31:0] MemoryRead;
  logic        Stall, AddrErrLoad, AddrErrStore;
  logic        DataReq, DataWr;
  logic [1:0]  DataSize;
  logic [31:0] DataAddr, DataWData;
  logic        DataAddrOk = 1'b0, DataDataOk = 1'b0;
  logic [31:0] DataRData = 32'h0;

  data_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn), .Mode(Mode),
    .MemoryExtend(MemoryExtend), .Addr(Addr), .MemoryWrite(MemoryWrite), .Flush(Flush),
    .MemoryRead(MemoryRead), .Stall(Stall), .AddrErrLoad(AddrErrLoad),
    .AddrErrStore(AddrErrStore), .DataReq(DataReq), .DataWr(DataWr), .DataSize(DataSize),
    .DataAddr(DataAddr), .DataWData(DataWData), .DataAddrOk(DataAddrOk),
    .DataDataOk(DataDataOk), .DataRData(DataRData)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wr; logic [1:0] size; logic [31:0] wdata; } bus_t;
  typedef struct { logic [31:0] rd; int stalls; } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  int    tests = 0, fails = 0;
  int    req_count = 0, exp_reqs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave: address accepted after cfg_awt wait cycles, data cfg_dlat cycles later
  int          cfg_awt = 0, cfg_dlat = 0;
  logic [31:0] cfg_rdata = 32'h0;
  int          s_phase = 0, s_acnt = 0, s_dcnt = 0;

  always @(negedge clk) begin
    DataAddrOk = 1'b0;
    DataDataOk = 1'b0;
    DataRData  = 32'h0;
    if (reset) begin
      s_phase = 0; s_acnt = 0; s_dcnt = 0;
    end else if (s_phase == 1) begin
      s_dcnt++;
      if (s_dcnt >= cfg_dlat) begin
        DataDataOk = 1'b1; DataRData = cfg_rdata; s_phase = 0;
      end
    end else if (DataReq) begin
      if (s_acnt >= cfg_awt) begin
        DataAddrOk = 1'b1; s_acnt = 0;
        if (cfg_dlat == 0) begin
          DataDataOk = 1'b1; DataRData = cfg_rdata;
        end else begin
          s_phase = 1; s_dcnt = 0;
        end
      end else begin
        s_acnt++;
      end
    end
  end

  // Monitor: bus request contents/stability and transaction completion
  logic  prev_req = 1'b0;
  bus_t  cur_bus;
  logic  in_txn = 1'b0;
  int    scount = 0;

  always @(negedge clk) begin
    if (DataReq && !prev_req) begin
      req_count++;
      if (bus_q.size() == 0) begin
        check("unexpected_request", 32'd1, 32'd0);
      end else begin
        cur_bus = bus_q.pop_front();
        check("bus_addr", DataAddr, cur_bus.addr);
        check("bus_wr", {31'd0, DataWr}, {31'd0, cur_bus.wr});
        check("bus_size", {30'd0, DataSize}, {30'd0, cur_bus.size});
        check("bus_wdata", DataWData, cur_bus.wdata);
      end
    end else if (DataReq && prev_req) begin
      check("bus_addr_stable", DataAddr, cur_bus.addr);
      check("bus_wdata_stable", DataWData, cur_bus.wdata);
    end
    prev_req = DataReq;

    if (reset) begin
      in_txn = 1'b0; scount = 0;
    end else if (Stall) begin
      in_txn = 1'b1; scount++;
    end else if (in_txn) begin
      if (resp_q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("memory_read", MemoryRead, r.rd);
        check("stall_cycles", scount, r.stalls);
      end
      in_txn = 1'b0; scount = 0;
    end
  end

  task automatic clear_inputs();
    MemReadEn = 1'b0; MemWriteEn = 1'b0; Mode = 2'b00; MemoryExtend = 1'b0;
    Addr = 32'h0; MemoryWrite = 32'h0; Flush = 1'b0;
  endtask

  // Issue one access at posedge+1 in IDLE; hold it while stalled (as the pipeline would).
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] mode,
                           input logic ext, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int awt, input int dlat,
                           input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_read, input int exp_stalls, input int flush_at);
    bus_t  b;
    resp_t r;
    int    n;
    cfg_awt = awt; cfg_dlat = dlat; cfg_rdata = rdata;
    b.addr = a; b.wr = wr; b.size = exp_size; b.wdata = exp_wdata;
    r.rd = exp_read; r.stalls = exp_stalls;
    bus_q.push_back(b);
    resp_q.push_back(r);
    exp_reqs++;
    MemReadEn = rd; MemWriteEn = wr; Mode = mode; MemoryExtend = ext; Addr = a; MemoryWrite = wd;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!Stall) break;
      n++;
      if (n == flush_at) Flush = 1'b1;
      if (n > 60) begin
        $display("FAIL timeout: stall never released after %0d cycles", n);
        $fatal(1, "timeout");
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_datareq", {31'd0, DataReq}, 32'd0);
    check("rst_datawr", {31'd0, DataWr}, 32'd0);
    check("rst_datasize", {30'd0, DataSize}, 32'd0);
    check("rst_dataaddr", DataAddr, 32'd0);
    check("rst_datawdata", DataWData, 32'd0);
    check("rst_memoryread", MemoryRead, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_errs", {30'd0, AddrErrLoad, AddrErrStore}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // rd wr mode ext addr wdata rdata awt dlat | size wdata_exp read_exp stalls flush_at
    do_access(1, 0, 2'b10, 0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 2'd2, 32'h0, 32'hDEAD_BEEF, 2, 0);
    do_access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 2'd0, 32'h0, 32'hFFFF_FF80, 2, 0);
    do_access(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0, 2'd0, 32'h0, 32'h0000_0080, 2, 0);
    do_access(0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0, 2'd1, 32'hABCD_ABCD, 32'h0000_0080, 2, 0);
    do_access(1, 0, 2'b01, 1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 2, 3, 2'd1, 32'h0, 32'hFFFF_8001, 7, 0);
    do_access(0, 1, 2'b00, 0, 32'h0000_0007, 32'h0000_00A5, 32'h0, 0, 0, 2'd0, 32'hA5A5_A5A5, 32'hFFFF_8001, 2, 0);
    do_access(1, 0, 2'b11, 1, 32'h0000_0008, 32'h0, 32'h1234_5678, 0, 0, 2'd2, 32'h0, 32'h1234_5678, 2, 0);
    do_access(1, 1, 2'b10, 0, 32'h0000_000C, 32'hCAFE_F00D, 32'h0, 0, 1, 2'd2, 32'hCAFE_F00D, 32'h1234_5678, 3, 0);
    do_access(1, 0, 2'b01, 0, 32'h0000_0000, 32'h0, 32'h1234_F00D, 0, 3, 2'd1, 32'h0, 32'h0000_F00D, 5, 3);

    // Misaligned load and store: error flagged, no stall, no bus request
    MemReadEn = 1'b1; Mode = 2'b10; Addr = 32'h6;
    #1;
    check("adel_flag", {31'd0, AddrErrLoad}, 32'd1);
    check("adel_stall", {31'd0, Stall}, 32'd0);
    check("adel_no_ades", {31'd0, AddrErrStore}, 32'd0);
    @(posedge clk); #1;
    check("adel_no_req", {31'd0, DataReq}, 32'd0);
    clear_inputs();
    MemWriteEn = 1'b1; Mode = 2'b01; Addr = 32'h5;
    #1;
    check("ades_flag", {31'd0, AddrErrStore}, 32'd1);
    check("ades_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    check("ades_no_req", {31'd0, DataReq}, 32'd0);

    // Flushed misaligned store: no error, no stall
    Flush = 1'b1;
    #1;
    check("flush_no_ades", {31'd0, AddrErrStore}, 32'd0);
    clear_inputs();
    // Flushed aligned load in IDLE: no transaction
    MemReadEn = 1'b1; Mode = 2'b10; Addr = 32'h20; Flush = 1'b1;
    #1;
    check("flush_idle_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    check("flush_idle_no_req", {31'd0, DataReq}, 32'd0);
    clear_inputs();
    @(posedge clk); #1;

    // Reset while the slave is withholding AddrOk
    begin
      bus_t b;
      b.addr = 32'h40; b.wr = 1'b0; b.size = 2'd2; b.wdata = 32'h0;
      bus_q.push_back(b);
      exp_reqs++;
      cfg_awt = 5; cfg_dlat = 0; cfg_rdata = 32'h0BAD_0BAD;
      MemReadEn = 1'b1; Mode = 2'b10; Addr = 32'h40;
      @(posedge clk); #1;
      check("rst_addr_req_high", {31'd0, DataReq}, 32'd1);
      reset = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_addr_req_low", {31'd0, DataReq}, 32'd0);
      check("rst_addr_stall_low", {31'd0, Stall}, 32'd0);
      check("rst_addr_memread", MemoryRead, 32'd0);
      check("rst_addr_dataaddr", DataAddr, 32'd0);
    end
    @(posedge clk); #1;

    do_access(1, 0, 2'b10, 0, 32'h0000_0044, 32'h0, 32'h55AA_55AA, 0, 0, 2'd2, 32'h0, 32'h55AA_55AA, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    check("request_count", req_count, exp_reqs);
    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
